// File: rtl/hop_pkg.sv
`default_nettype none
// ---- hop_pkg : shared state encoding and LFSR constants for the hop lane checker (rev 1.0) ----
package hop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } hop_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hop_lfsr16.sv
`default_nettype none
// ---- hop_lfsr16 : 16-bit Fibonacci LFSR with reseed and single-step controls (rev 1.0) ----
module hop_lfsr16
  import hop_pkg::*;
(
  input  logic        clock0,
  input  logic        rst1,
  input  logic        load,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = LFSR_SEED;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      value_q <= LFSR_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/hop_lane_checker.sv
`default_nettype none
// ---- hop_lane_checker : drives LFSR stimulus into hop lanes and checks the delayed returns (rev 1.0) ----
module hop_lane_checker
  import hop_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int LATENCY = 5,
  parameter int RUN_LEN = 256,
  parameter int ERR_W   = 8
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             go,
  output logic [LANES-1:0] start,
  input  logic [LANES-1:0] ret,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [LANES-1:0] err_lane
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LATENCY - 1);

  hop_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0] start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [LANES-1:0] err_lane_q, err_lane_d;
  logic [LANES-1:0] exp_q [LATENCY];
  logic [LANES-1:0] exp_d [LATENCY];
  logic [LATENCY-1:0] vld_q, vld_d;

  logic        go_ok;
  logic [15:0] lfsr_value;
  logic [15:0] lfsr_nxt;
  logic        lfsr_nxt_unused;
  logic [LANES-1:0] mism;

  assign go_ok = go && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  hop_lfsr16 u_lfsr (
    .clock0 (clock0),
    .rst1   (rst1),
    .load   (go_ok),
    .step   (state_q == ST_SEND),
    .value  (lfsr_value)
  );

  // start_q is loaded with the value the LFSR will hold next, so it tracks the LFSR in every SEND cycle.
  assign lfsr_nxt        = lfsr_next(lfsr_value);
  assign lfsr_nxt_unused = ^lfsr_nxt;
  assign mism            = (ret ^ exp_q[LATENCY-1]) & {LANES{vld_q[LATENCY-1]}};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = '0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    err_lane_d = err_lane_q;

    exp_d[0] = start_q;
    vld_d[0] = (state_q == ST_SEND);
    for (int i = 1; i < LATENCY; i++) begin
      exp_d[i] = exp_q[i-1];
      vld_d[i] = vld_q[i-1];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          start_d = LFSR_SEED[LANES-1:0];
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (cnt_q == SEND_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          start_d = lfsr_nxt[LANES-1:0];
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_ok) begin
      err_cnt_d  = '0;
      err_lane_d = '0;
      vld_d      = '0;
      for (int i = 0; i < LATENCY; i++) begin
        exp_d[i] = '0;
      end
    end else if (|mism) begin
      err_lane_d = err_lane_q | mism;
      if (err_cnt_q != {ERR_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end

    pass_d = done_d && (err_cnt_d == '0);
  end

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      start_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_lane_q <= '0;
      exp_q      <= '{default: '0};
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_lane_q <= err_lane_d;
      exp_q      <= exp_d;
      vld_q      <= vld_d;
    end
  end

  assign start    = start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_lane = err_lane_q;

endmodule
`default_nettype wire

// File: tb/tb_hop_lane_checker.sv
`default_nettype none
// ---- tb_hop_lane_checker : randomized run-level check of hop_lane_checker against a reference model (rev 1.0) ----
module tb_hop_lane_checker;

  localparam int LAT = 5;
  localparam int RUN = 256;

  logic       clock0 = 1'b0;
  logic       rst1 = 1'b1;
  logic       go = 1'b0;
  logic [3:0] start, ret, err_lane;
  logic [3:0] start_s, ret_s, err_lane_s;
  logic       busy, done, pass;
  logic       busy_s, done_s, pass_s;
  logic [7:0] err_cnt;
  logic [3:0] err_cnt_s;

  int total = 0;
  int bad = 0;

  logic [15:0] lfsr_tab [RUN];
  logic [3:0]  hist      [600];
  logic [3:0]  hist_s    [600];
  logic [3:0]  ret_log   [600];
  logic [3:0]  ret_s_log [600];

  always #5 clock0 = ~clock0;

  hop_lane_checker #(.LANES(4), .LATENCY(LAT), .RUN_LEN(RUN), .ERR_W(8)) dut (
    .clock0(clock0), .rst1(rst1), .go(go), .start(start), .ret(ret),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_lane(err_lane)
  );

  // Second instance sees inverted returns to exercise counter saturation.
  hop_lane_checker #(.LANES(4), .LATENCY(LAT), .RUN_LEN(RUN), .ERR_W(4)) dut_s (
    .clock0(clock0), .rst1(rst1), .go(go), .start(start_s), .ret(ret_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s), .err_lane(err_lane_s)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    int unsigned x, b;
    x = v;
    b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (b << 15));
  endfunction

  // Lane chain behaviour: 0 ideal 5-flop, 1 lane 2 stuck low, 2 six-flop, 3 random bit flips.
  function automatic logic [3:0] chan(input int mode, input int c);
    logic [3:0] v;
    int d;
    d = (mode == 2) ? 6 : 5;
    v = (c >= d) ? hist[c-d] : 4'h0;
    if (mode == 1) v[2] = 1'b0;
    if (mode == 3 && $urandom_range(0, 5) == 0) v = v ^ 4'($urandom_range(1, 15));
    return v;
  endfunction

  task automatic do_run(input int mode, input bit go_mid, input int rst_at);
    int busy_len, c, n_err, n_err_s;
    logic [3:0] lanes, lanes_s, m;
    bit fin;
    busy_len = 0;
    fin = 1'b0;
    @(negedge clock0);
    rst1 = 1'b0;
    go = 1'b1;
    for (c = 0; c < 600; c++) begin
      @(negedge clock0);
      go = 1'b0;
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (busy) busy_len++;
      hist[c] = start;
      hist_s[c] = start_s;
      if (c < RUN) check_val("start", start, lfsr_tab[c][3:0]);
      else check_val("start_idle", start, 0);
      if (c == 0) begin
        check_val("clr_err_cnt", err_cnt, 0);
        check_val("clr_err_lane", err_lane, 0);
        check_val("clr_done", done, 0);
      end
      if (c == rst_at) begin
        #2 rst1 = 1'b1;
        #1;
        check_val("rst_start", start, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err_cnt", err_cnt, 0);
        check_val("rst_err_lane", err_lane, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err_cnt_s", err_cnt_s, 0);
        #1 rst1 = 1'b0;
        ret = 4'h0;
        ret_s = 4'h0;
        return;
      end
      ret = chan(mode, c);
      ret_s = ~((c >= LAT) ? hist_s[c-LAT] : 4'h0);
      ret_log[c] = ret;
      ret_s_log[c] = ret_s;
      if (go_mid && (c == 50 || c == RUN + 2)) go = 1'b1;
    end
    check_val("done_seen", fin, 1);
    n_err = 0;
    n_err_s = 0;
    lanes = 4'h0;
    lanes_s = 4'h0;
    for (int k = 0; k < RUN; k++) begin
      m = ret_log[k+LAT] ^ lfsr_tab[k][3:0];
      if (m != 4'h0) begin
        n_err++;
        lanes = lanes | m;
      end
      m = ret_s_log[k+LAT] ^ lfsr_tab[k][3:0];
      if (m != 4'h0) begin
        n_err_s++;
        lanes_s = lanes_s | m;
      end
    end
    check_val("busy_len", busy_len, RUN + LAT);
    check_val("busy_end", busy, 0);
    check_val("done", done, 1);
    check_val("err_cnt", err_cnt, (n_err > 255) ? 255 : n_err);
    check_val("err_lane", err_lane, lanes);
    check_val("pass", pass, (n_err == 0) ? 1 : 0);
    check_val("sat_err_cnt", err_cnt_s, (n_err_s > 15) ? 15 : n_err_s);
    check_val("sat_err_lane", err_lane_s, lanes_s);
    check_val("sat_done", done_s, 1);
    check_val("sat_busy", busy_s, 0);
    check_val("sat_pass", pass_s, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    ret = 4'h0;
    ret_s = 4'h0;
    v = 16'hACE1;
    for (int k = 0; k < RUN; k++) begin
      lfsr_tab[k] = v;
      v = ref_step(v);
    end

    repeat (3) @(negedge clock0);
    check_val("reset_start", start, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_pass", pass, 0);
    check_val("reset_err_cnt", err_cnt, 0);
    check_val("reset_err_lane", err_lane, 0);

    do_run(0, 1'b0, -1);
    check_val("ideal_lanes", err_lane, 4'h0);
    check_val("ideal_pass", pass, 1);
    do_run(1, 1'b0, -1);
    check_val("lane2_lanes", err_lane, 4'h4);
    do_run(2, 1'b0, -1);
    check_val("six_flop_lanes", err_lane, 4'hF);
    do_run(1, 1'b0, 100);
    repeat (4) @(negedge clock0);
    check_val("idle_busy", busy, 0);
    check_val("idle_start", start, 0);
    do_run(0, 1'b1, -1);
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge clock0);
      check_val("done_hold", done, 1);
      do_run(3, ($urandom_range(0, 1) == 1), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
